// File: rtl/salu_arbiter_if.sv
// Requester / ALU / response bundle for the scalar-ALU arbiter.
// Requester i occupies slice [i] of every packed per-requester field.
interface salu_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    // control
    logic                                 flush_i;
    logic                                 busy_o;

    // request channels
    logic [NUM_REQ-1:0]                   req_valid_i;
    logic [NUM_REQ-1:0]                   req_ready_o;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs1_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs2_i;
    logic [NUM_REQ-1:0][3:0]              req_op_i;

    // shared ALU
    logic [DATA_WIDTH-1:0]                alu_rs1_o;
    logic [DATA_WIDTH-1:0]                alu_rs2_o;
    logic [3:0]                           alu_op_o;
    logic [DATA_WIDTH-1:0]                alu_res_i;
    logic [2:0]                           alu_flags_i;

    // response channels
    logic [NUM_REQ-1:0]                   rsp_valid_o;
    logic [NUM_REQ-1:0]                   rsp_ready_i;
    logic [DATA_WIDTH-1:0]                rsp_res_o;
    logic [2:0]                           rsp_flags_o;

    // arbiter side
    modport slave (
        input  flush_i, req_valid_i, req_rs1_i, req_rs2_i, req_op_i,
               alu_res_i, alu_flags_i, rsp_ready_i,
        output busy_o, req_ready_o, alu_rs1_o, alu_rs2_o, alu_op_o,
               rsp_valid_o, rsp_res_o, rsp_flags_o
    );

    // requester / ALU side
    modport master (
        output flush_i, req_valid_i, req_rs1_i, req_rs2_i, req_op_i,
               alu_res_i, alu_flags_i, rsp_ready_i,
        input  busy_o, req_ready_o, alu_rs1_o, alu_rs2_o, alu_op_o,
               rsp_valid_o, rsp_res_o, rsp_flags_o
    );
endinterface

// File: rtl/salu_arbiter.sv
// Round-robin sharing of one registered scalar ALU between NUM_REQ requesters.
// Accept in cycle N -> ALU result valid in N+1 -> pushed into a 2-entry
// in-order response FIFO -> response visible from N+2. A credit check on
// (FIFO count + in-flight op - pop) keeps the FIFO from ever overflowing.
module salu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    salu_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] res;
        logic [2:0]            flags;
    } rsp_entry_t;

    // pipeline / FIFO state
    rsp_entry_t       fifo_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             inflight_v;
    logic [ID_W-1:0]  inflight_id;
    logic [ID_W-1:0]  rr_last;

    // combinational control
    rsp_entry_t       head;
    logic             fifo_nempty;
    logic             pop;
    logic             push;
    logic [2:0]       occ_after;
    logic             can_issue;
    logic             gnt_v;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  scan_id;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;

    assign head        = fifo_q[rd_ptr];
    assign fifo_nempty = (count != 2'd0);

    // A flush cycle ignores the response handshake and drops the ALU result.
    assign pop  = fifo_nempty && bus.rsp_ready_i[head.id] && !bus.flush_i;
    assign push = inflight_v && !bus.flush_i;

    // Entries that will still be held after this cycle; a new op needs one
    // free slot for when its result lands next cycle.
    assign occ_after = {1'b0, count} + {2'b00, inflight_v} - {2'b00, pop};
    assign can_issue = rst_n && !bus.flush_i && (occ_after < 3'd2);

    // Round-robin search starting just past the last winner, wrapping at NUM_REQ.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_id  = '0;
        scan_id = rr_last;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = (scan_id == ID_W'(NUM_REQ - 1)) ? '0 : scan_id + ID_W'(1);
            if (can_issue && !gnt_v && bus.req_valid_i[scan_id]) begin
                gnt_v  = 1'b1;
                gnt_id = scan_id;
            end
        end
    end

    // One-hot accept to the winner only.
    always_comb begin
        req_ready = '0;
        if (gnt_v)
            req_ready[gnt_id] = 1'b1;
    end

    assign bus.req_ready_o = req_ready;

    // Steer the winner's operands to the ALU; idle cycles issue a harmless ADD 0,0.
    always_comb begin
        bus.alu_rs1_o = '0;
        bus.alu_rs2_o = '0;
        bus.alu_op_o  = 4'b0000;
        if (gnt_v) begin
            bus.alu_rs1_o = bus.req_rs1_i[gnt_id];
            bus.alu_rs2_o = bus.req_rs2_i[gnt_id];
            bus.alu_op_o  = bus.req_op_i[gnt_id];
        end
    end

    // Track the op currently inside the ALU and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_v  <= 1'b0;
            inflight_id <= '0;
            rr_last     <= ID_W'(NUM_REQ - 1);
        end else begin
            // gnt_v is already low during flush, which also kills the in-flight op
            inflight_v <= gnt_v;
            if (gnt_v) begin
                inflight_id <= gnt_id;
                rr_last     <= gnt_id;
            end
        end
    end

    // Response FIFO: captures the ALU result one cycle after issue, pops on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++)
                fifo_q[e] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (bus.flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{id: inflight_id, res: bus.alu_res_i, flags: bus.alu_flags_i};
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Response valid goes only to the owner of the FIFO head.
    always_comb begin
        rsp_valid = '0;
        if (fifo_nempty)
            rsp_valid[head.id] = 1'b1;
    end

    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_res_o   = head.res;
    assign bus.rsp_flags_o = head.flags;
    assign bus.busy_o      = inflight_v | fifo_nempty;

    // The credit rule must keep pushes away from a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == 2'd2));

    // At most one requester is accepted per cycle.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

endmodule

// File: tb/tb_salu_arbiter.sv
// Self-checking bench for salu_arbiter: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_salu_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int IW = $clog2(NR);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    salu_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    salu_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU: returns {ovf, neg, zero, result}.
    function automatic logic [DW+2:0] alu_ref(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          ov;
        ov = 1'b0;
        case (op)
            4'd1: begin r = a - b; ov = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: begin r = a + b; ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
        endcase
        return {ov, r[DW-1], (r == '0), r};
    endfunction

    // Registered ALU model sharing the arbiter's reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {bus.alu_flags_i, bus.alu_res_i} <= '0;
        else
            {bus.alu_flags_i, bus.alu_res_i} <= alu_ref(bus.alu_op_o, bus.alu_rs1_o, bus.alu_rs2_o);
    end

    task automatic drive_idle();
        bus.flush_i     = 1'b0;
        bus.req_valid_i = '0;
        bus.req_rs1_i   = '0;
        bus.req_rs2_i   = '0;
        bus.req_op_i    = '0;
        bus.rsp_ready_i = '1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        bus.req_valid_i = 2'b11;
        bus.req_rs1_i[0] = 32'h1234;
        @(negedge clk); #1;
        n_checks++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready_o); end
        n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid_o); end
        n_checks++; if ({bus.rsp_flags_o, bus.rsp_res_o} !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h/%b want 0", bus.rsp_res_o, bus.rsp_flags_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_checks++; if ({bus.alu_rs1_o, bus.alu_rs2_o, bus.alu_op_o} !== '0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h want 0", bus.alu_rs1_o, bus.alu_rs2_o, bus.alu_op_o); end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // SUB from req0 and XOR from req1 presented together.
    task automatic test_two_requesters();
        @(negedge clk);
        bus.req_valid_i = 2'b11;
        bus.req_op_i[0] = OP_SUB; bus.req_rs1_i[0] = 32'd3;    bus.req_rs2_i[0] = 32'd5;
        bus.req_op_i[1] = OP_XOR; bus.req_rs1_i[1] = 32'hF0;   bus.req_rs2_i[1] = 32'hFF;
        bus.rsp_ready_i = 2'b11;
        #1;
        n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL two_grant0: got %b want 01", bus.req_ready_o); end
        n_checks++; if (bus.alu_op_o !== OP_SUB || bus.alu_rs1_o !== 32'd3) begin n_fail++; $display("FAIL two_alu_drive: got op %h rs1 %h want 1/3", bus.alu_op_o, bus.alu_rs1_o); end
        @(negedge clk);
        bus.req_valid_i = 2'b10;
        #1;
        n_checks++; if (bus.req_ready_o !== 2'b10) begin n_fail++; $display("FAIL two_grant1: got %b want 10", bus.req_ready_o); end
        @(negedge clk);
        bus.req_valid_i = 2'b00;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL two_rsp0_valid: got %b want 01", bus.rsp_valid_o); end
        n_checks++; if (bus.rsp_res_o !== 32'hFFFFFFFE || bus.rsp_flags_o !== 3'b010) begin n_fail++; $display("FAIL two_rsp0_data: got %h/%b want fffffffe/010", bus.rsp_res_o, bus.rsp_flags_o); end
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL two_rsp1_valid: got %b want 10", bus.rsp_valid_o); end
        n_checks++; if (bus.rsp_res_o !== 32'h0000000F || bus.rsp_flags_o !== 3'b000) begin n_fail++; $display("FAIL two_rsp1_data: got %h/%b want 0000000f/000", bus.rsp_res_o, bus.rsp_flags_o); end
        @(negedge clk); #1;
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL two_drained: busy %b want 0", bus.busy_o); end
    endtask

    // Hold rsp_ready low with both requesters hammering, then release.
    task automatic test_backpressure();
        int            ncnt [2];
        int            rsp_id [$];
        logic [DW-1:0] rsp_val [$];
        int            post [$];
        int            acc;
        int            rid;
        ncnt[0] = 0; ncnt[1] = 0; acc = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.req_valid_i  = (c < 12) ? 2'b11 : 2'b00;
            bus.rsp_ready_i  = (c < 6) ? 2'b00 : 2'b11;
            bus.req_op_i     = '0;
            bus.req_rs2_i    = '0;
            bus.req_rs1_i[0] = 32'h100 + DW'(ncnt[0]);
            bus.req_rs1_i[1] = 32'h200 + DW'(ncnt[1]);
            #1;
            if (c >= 2 && c < 6) begin
                n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_res_o !== 32'h100) begin n_fail++; $display("FAIL bp_head_hold c%0d: got %b/%h want 01/100", c, bus.rsp_valid_o, bus.rsp_res_o); end
            end
            if (c == 5) begin
                n_checks++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc); end
                n_checks++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready: got %b want 00", bus.req_ready_o); end
            end
            if (c >= 6 && bus.rsp_valid_o !== 2'b00) begin
                rid = (bus.rsp_valid_o == 2'b01) ? 0 : (bus.rsp_valid_o == 2'b10) ? 1 : -1;
                n_checks++;
                if (rsp_id.size() == 0 || rid != rsp_id[0] || bus.rsp_res_o !== rsp_val[0]) begin
                    n_fail++; $display("FAIL bp_rsp_order c%0d: got id %0d res %h", c, rid, bus.rsp_res_o);
                end
                if (rsp_id.size() != 0) begin void'(rsp_id.pop_front()); void'(rsp_val.pop_front()); end
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready_o[IW'(i)]) begin
                    rsp_id.push_back(i);
                    rsp_val.push_back(32'h100 * DW'(i + 1) + DW'(ncnt[i]));
                    if (c >= 6) post.push_back(i);
                    ncnt[i]++;
                    acc++;
                end
            end
        end
        n_checks++;
        if (post.size() < 4 || post[0] != 0 || post[1] != 1 || post[2] != 0 || post[3] != 1) begin
            n_fail++; $display("FAIL bp_alternate: got %0d grants after release, first %p", post.size(), post);
        end
        n_checks++; if (rsp_id.size() != 0) begin n_fail++; $display("FAIL bp_all_returned: %0d responses missing", rsp_id.size()); end
    endtask

    task automatic test_single_add();
        @(negedge clk);
        bus.req_valid_i = 2'b01; bus.req_op_i[0] = OP_ADD;
        bus.req_rs1_i[0] = 32'd5; bus.req_rs2_i[0] = 32'd7; bus.rsp_ready_i = 2'b11;
        #1;
        n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b want 01", bus.req_ready_o); end
        @(negedge clk);
        bus.req_valid_i = 2'b00;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL add_n1: rsp %b busy %b want 00/1", bus.rsp_valid_o, bus.busy_o); end
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b want 01", bus.rsp_valid_o); end
        n_checks++; if (bus.rsp_res_o !== 32'h0000000C || bus.rsp_flags_o !== 3'b000) begin n_fail++; $display("FAIL add_rsp_data: got %h/%b want 0000000c/000", bus.rsp_res_o, bus.rsp_flags_o); end
        @(negedge clk); #1;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        bus.req_valid_i = 2'b01; bus.req_op_i[0] = OP_ADD;
        bus.req_rs1_i[0] = 32'h7FFFFFFF; bus.req_rs2_i[0] = 32'd1; bus.rsp_ready_i = 2'b11;
        @(negedge clk);
        bus.req_valid_i = 2'b00;
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_res_o !== 32'h80000000 || bus.rsp_flags_o !== 3'b110) begin
            n_fail++; $display("FAIL ovf_rsp: got %b %h %b want 01 80000000 110", bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_flags_o);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b00; bus.req_op_i = '0;
            #1;
            n_checks++; if (bus.req_ready_o === 2'b00) begin n_fail++; $display("FAIL flush_fill c%0d: no accept", c); end
        end
        @(negedge clk);
        bus.flush_i = 1'b1; bus.rsp_ready_i = 2'b11;
        #1;
        n_checks++; if (bus.req_ready_o !== 2'b00 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL flush_cycle: ready %b busy %b want 00/1", bus.req_ready_o, bus.busy_o); end
        @(negedge clk);
        bus.flush_i = 1'b0; bus.req_valid_i = 2'b01;
        bus.req_op_i[0] = OP_ADD; bus.req_rs1_i[0] = 32'd1; bus.req_rs2_i[0] = 32'd2;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_after: rsp %b busy %b want 00/0", bus.rsp_valid_o, bus.busy_o); end
        n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL flush_resume: got %b want 01", bus.req_ready_o); end
        @(negedge clk);
        bus.req_valid_i = 2'b00;
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_res_o !== 32'd3) begin n_fail++; $display("FAIL flush_fresh_rsp: got %b/%h want 01/3", bus.rsp_valid_o, bus.rsp_res_o); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b00;
            bus.req_op_i = '0; bus.req_rs1_i[0] = 32'd9; bus.req_rs1_i[1] = 32'd9;
        end
        #1;
        n_checks++; if (bus.busy_o !== 1'b1 || bus.rsp_valid_o === 2'b00) begin n_fail++; $display("FAIL rmid_loaded: busy %b rsp %b", bus.busy_o, bus.rsp_valid_o); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.busy_o} !== '0) begin n_fail++; $display("FAIL rmid_ctrl: rsp %b ready %b busy %b want 0", bus.rsp_valid_o, bus.req_ready_o, bus.busy_o); end
        n_checks++; if ({bus.rsp_res_o, bus.rsp_flags_o, bus.alu_rs1_o, bus.alu_op_o} !== '0) begin n_fail++; $display("FAIL rmid_data: res %h flags %b alu %h want 0", bus.rsp_res_o, bus.rsp_flags_o, bus.alu_rs1_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b11;
        bus.req_rs1_i[0] = 32'd10; bus.req_rs2_i[0] = 32'd20; bus.req_op_i[0] = OP_ADD;
        #1;
        n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rmid_priority: got %b want 01", bus.req_ready_o); end
        @(negedge clk);
        bus.req_valid_i = 2'b00;
        #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rmid_early: got %b want 00", bus.rsp_valid_o); end
        @(negedge clk); #1;
        n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_res_o !== 32'd30) begin n_fail++; $display("FAIL rmid_rsp: got %b/%h want 01/1e", bus.rsp_valid_o, bus.rsp_res_o); end
        @(negedge clk); #1;
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom % 4)
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return DW'($urandom % 4);
            default: return DW'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [IW-1:0]  id;
        logic [DW+2:0]  v;
        int             cyc;
    } exp_t;

    // Random traffic vs. model: outstanding ops in a queue, credit = 2.
    task automatic test_random();
        exp_t          q [$];
        exp_t          e;
        logic [NR-1:0] hold;
        logic [NR-1:0] exp_rv;
        logic [NR-1:0] exp_rdy;
        int            rr;
        int            g;
        int            idx;
        bit            pop;
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr   = NR - 1;
        hold = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (k >= 390) begin
                    bus.req_valid_i[IW'(i)] = 1'b0;
                    bus.rsp_ready_i[IW'(i)] = 1'b1;
                end else begin
                    if (hold[IW'(i)]) begin
                        bus.req_valid_i[IW'(i)] = ($urandom % 4) != 0;
                    end else begin
                        bus.req_valid_i[IW'(i)] = ($urandom % 5) < 3;
                        bus.req_op_i[IW'(i)]    = 4'($urandom % 5);
                        bus.req_rs1_i[IW'(i)]   = pick_operand();
                        bus.req_rs2_i[IW'(i)]   = pick_operand();
                    end
                    bus.rsp_ready_i[IW'(i)] = ($urandom % 4) != 0;
                end
            end
            #1;
            exp_rv = '0;
            if (q.size() > 0 && q[0].cyc <= k - 2) exp_rv[q[0].id] = 1'b1;
            n_checks++; if (bus.rsp_valid_o !== exp_rv) begin n_fail++; $display("FAIL rnd_rsp_valid k%0d: got %b want %b", k, bus.rsp_valid_o, exp_rv); end
            if (exp_rv != '0) begin
                n_checks++; if ({bus.rsp_flags_o, bus.rsp_res_o} !== q[0].v) begin n_fail++; $display("FAIL rnd_rsp_data k%0d: got %b/%h want %h", k, bus.rsp_flags_o, bus.rsp_res_o, q[0].v); end
            end
            n_checks++; if (bus.busy_o !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy k%0d: got %b want %0d", k, bus.busy_o, q.size() != 0); end
            pop = (exp_rv != '0) && bus.rsp_ready_i[q[0].id];
            exp_rdy = '0;
            g = -1;
            if (q.size() - int'(pop) < 2) begin
                for (int s = 1; s <= NR; s++) begin
                    idx = (rr + s) % NR;
                    if (g < 0 && bus.req_valid_i[IW'(idx)]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
            n_checks++; if (bus.req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant k%0d: got %b want %b", k, bus.req_ready_o, exp_rdy); end
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                e.id  = IW'(g);
                e.v   = alu_ref(bus.req_op_i[IW'(g)], bus.req_rs1_i[IW'(g)], bus.req_rs2_i[IW'(g)]);
                e.cyc = k;
                q.push_back(e);
                rr = g;
            end
            hold = bus.req_valid_i & ~bus.req_ready_o;
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d responses outstanding", q.size()); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_two_requesters();
        test_backpressure();
        test_single_add();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks done", n_checks);
        $fatal(1, "timeout");
    end
endmodule
